// File: rtl/serial_demux_32_pkg.sv
// Shared constants for the serial bit-steering deserializer.
package serial_demux_32_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_IDX_W = 5;

endpackage

// File: rtl/serial_demux_32_decoder.sv
// 5-to-32 one-hot write-enable decoder; all outputs low when disabled.
module decoder_5_32 (
    input  logic [4:0]  i_idx,
    input  logic        i_en,
    output logic [31:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/serial_demux_32.sv
// Serial-to-parallel deserializer: each accepted bit is steered into its word
// position through a one-hot decoder, and full words leave on a registered valid/ready port.
module serial_demux_32
    import serial_demux_32_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int IDX_W     = DEFAULT_IDX_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] bit_count
);

    logic [1:0]       r_rstSync;
    logic             w_rstN;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] r_outData;
    logic             r_outValid;
    logic             w_last;
    logic             w_inReady;
    logic             w_accept;
    logic [IDX_W-1:0] w_pos;
    logic [31:0]      w_we32;
    logic [WIDTH-1:0] w_we;
    logic [WIDTH-1:0] w_nextWord;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_rstN = r_rstSync[1];

    assign w_last    = (r_idx == IDX_W'(WIDTH - 1));
    assign w_inReady = w_rstN && !clear && !(w_last && r_outValid && !out_ready);
    assign w_accept  = in_valid && w_inReady;
    assign w_pos     = MSB_FIRST ? (IDX_W'(WIDTH - 1) - r_idx) : r_idx;

    decoder_5_32 u_decoder (
        .i_idx    (5'(w_pos)),
        .i_en     (w_accept),
        .o_onehot (w_we32)
    );

    assign w_we = w_we32[WIDTH-1:0];

    always_comb begin
        w_nextWord = r_asm;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_we[i]) begin
                w_nextWord[i] = in_bit;
            end
        end
    end

    // A final accept reloads the output even while the old word is being taken,
    // so back-to-back words leave without a bubble.
    always_ff @(posedge clock or negedge w_rstN) begin
        if (!w_rstN) begin
            r_idx      <= '0;
            r_asm      <= '0;
            r_outData  <= '0;
            r_outValid <= 1'b0;
        end else begin
            if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
            if (clear) begin
                r_idx <= '0;
                r_asm <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_outData  <= w_nextWord;
                    r_outValid <= 1'b1;
                    r_idx      <= '0;
                    r_asm      <= '0;
                end else begin
                    r_asm <= w_nextWord;
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign in_ready  = w_inReady;
    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign bit_count = r_idx;

endmodule

// File: tb/tb_serial_demux_32.sv
// Directed self-checking bench for serial_demux_32 (LSB-first and MSB-first instances).
module tb_serial_demux_32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        in_bit = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  bit_count;

    logic        mClear = 1'b0;
    logic        mInBit = 1'b0;
    logic        mInValid = 1'b0;
    logic        mInReady;
    logic [31:0] mOutData;
    logic        mOutValid;
    logic        mOutReady = 1'b1;
    logic [4:0]  mBitCount;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    serial_demux_32 dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bit_count (bit_count)
    );

    serial_demux_32 #(.MSB_FIRST(1'b1)) dutMsb (
        .clock     (clock),
        .reset     (reset),
        .clear     (mClear),
        .in_bit    (mInBit),
        .in_valid  (mInValid),
        .in_ready  (mInReady),
        .out_data  (mOutData),
        .out_valid (mOutValid),
        .out_ready (mOutReady),
        .bit_count (mBitCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Offers one bit to the LSB-first instance; every call expects it to be accepted.
    task automatic applyStimulus(input logic b);
        @(negedge clock);
        in_bit   = b;
        in_valid = 1'b1;
        #1;
        checkOutput("in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic sendWord(input logic [31:0] w, input int nBits);
        for (int i = 0; i < nBits; i++) begin
            applyStimulus(w[i]);
        end
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic sendWordMsb(input logic [31:0] w);
        for (int k = 0; k < 32; k++) begin
            @(negedge clock);
            mInBit   = w[31-k];
            mInValid = 1'b1;
            #1;
            checkOutput("msb bit_count", 32'(mBitCount), 32'(k));
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        mInValid = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_data", out_data, 32'h0);
        checkOutput("reset bit_count", 32'(bit_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

        // Test 1: LSB-first word, single-cycle out_valid
        sendWord(32'hDEADBEEF, 31);
        @(negedge clock);
        in_bit   = 1'b1;
        in_valid = 1'b1;
        #1;
        checkOutput("t1 valid before final", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("t1 out_valid", 32'(out_valid), 32'd1);
        checkOutput("t1 out_data", out_data, 32'hDEADBEEF);
        checkOutput("t1 bit_count", 32'(bit_count), 32'd0);
        idle();
        checkOutput("t1 valid one cycle", 32'(out_valid), 32'd0);

        // Test 2: MSB-first instance
        sendWordMsb(32'h80000001);
        #1;
        checkOutput("t2 out_valid", 32'(mOutValid), 32'd1);
        checkOutput("t2 out_data", mOutData, 32'h80000001);
        checkOutput("t2 bit_count wrap", 32'(mBitCount), 32'd0);
        sendWordMsb(32'h12345678);
        #1;
        checkOutput("t2 asym out_data", mOutData, 32'h12345678);

        // Test 3: backpressure while the next word assembles
        out_ready = 1'b0;
        sendWord(32'h12345678, 32);
        checkOutput("t3 A valid", 32'(out_valid), 32'd1);
        checkOutput("t3 A data", out_data, 32'h12345678);
        sendWord(32'hCAFEF00D, 31);
        checkOutput("t3 bit_count 31", 32'(bit_count), 32'd31);
        checkOutput("t3 A held", out_data, 32'h12345678);
        @(negedge clock);
        in_bit   = 1'b1;
        in_valid = 1'b1;
        #1;
        checkOutput("t3 stall in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("t3 stall bit_count", 32'(bit_count), 32'd31);
        checkOutput("t3 stall data", out_data, 32'h12345678);
        checkOutput("t3 stall valid", 32'(out_valid), 32'd1);
        @(negedge clock);
        out_ready = 1'b1;
        #1;
        checkOutput("t3 release in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        checkOutput("t3 B valid", 32'(out_valid), 32'd1);
        checkOutput("t3 B data", out_data, 32'hCAFEF00D);
        idle();
        checkOutput("t3 drained", 32'(out_valid), 32'd0);

        // Test 4: take and reload in the same cycle
        out_ready = 1'b0;
        sendWord(32'h00000000, 32);
        sendWord(32'hFFFFFFFF, 31);
        @(negedge clock);
        in_bit    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("t4 first valid", 32'(out_valid), 32'd1);
        checkOutput("t4 first data", out_data, 32'h00000000);
        @(posedge clock);
        #1;
        checkOutput("t4 second valid", 32'(out_valid), 32'd1);
        checkOutput("t4 second data", out_data, 32'hFFFFFFFF);
        idle();
        checkOutput("t4 drained", 32'(out_valid), 32'd0);

        // Test 5: clear aborts the partial word, pending output survives
        out_ready = 1'b0;
        sendWord(32'h55AA55AA, 32);
        sendWord(32'hFFFFFFFF, 10);
        checkOutput("t5 bit_count 10", 32'(bit_count), 32'd10);
        @(negedge clock);
        clear    = 1'b1;
        in_bit   = 1'b1;
        in_valid = 1'b1;
        #1;
        checkOutput("t5 clear in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("t5 clear bit_count", 32'(bit_count), 32'd0);
        checkOutput("t5 pending valid", 32'(out_valid), 32'd1);
        checkOutput("t5 pending data", out_data, 32'h55AA55AA);
        @(negedge clock);
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("t5 pending taken", 32'(out_valid), 32'd0);
        sendWord(32'h0F0F0F0F, 32);
        checkOutput("t5 valid", 32'(out_valid), 32'd1);
        checkOutput("t5 data", out_data, 32'h0F0F0F0F);
        idle();

        // Test 6: asynchronous reset mid-word and mid-cycle
        out_ready = 1'b0;
        sendWord(32'h11111111, 32);
        sendWord(32'h00000003, 17);
        checkOutput("t6 bit_count 17", 32'(bit_count), 32'd17);
        #3;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("t6 reset valid", 32'(out_valid), 32'd0);
        checkOutput("t6 reset data", out_data, 32'h0);
        checkOutput("t6 reset bit_count", 32'(bit_count), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("t6 no spurious valid", 32'(out_valid), 32'd0);
        checkOutput("t6 in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        sendWord(32'hA5A5A5A5, 32);
        checkOutput("t6 valid", 32'(out_valid), 32'd1);
        checkOutput("t6 data", out_data, 32'hA5A5A5A5);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
